// File: rtl/alu_exec.sv
// 16-bit ALU with add/and/or/shifts in 1 cycle and a 16-cycle shift-add multiply.
// No input queuing: start is only accepted while busy is low.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  signal,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

  state_t      state;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [15:0] mplr;
  logic [3:0]  count;

  logic [16:0] sum;
  logic [15:0] alu_res;
  logic        alu_cout;
  logic [15:0] acc_next;

  // Single-cycle datapath; unused codes (110/111) fall through to add.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    alu_res  = sum[15:0];
    alu_cout = sum[16];
    case (signal)
      OP_AND: begin
        alu_res  = a & b;
        alu_cout = 1'b0;
      end
      OP_OR: begin
        alu_res  = a | b;
        alu_cout = 1'b0;
      end
      OP_SLL: begin
        alu_res  = a << b[3:0];
        alu_cout = 1'b0;
      end
      OP_SRL: begin
        alu_res  = a >> b[3:0];
        alu_cout = 1'b0;
      end
      default: begin
        alu_res  = sum[15:0];
        alu_cout = sum[16];
      end
    endcase
  end

  assign acc_next = acc + (mplr[0] ? mcand : 16'h0000);
  assign zero     = (result == 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= 16'h0000;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= 16'h0000;
      mcand  <= 16'h0000;
      mplr   <= 16'h0000;
      count  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (signal == OP_MUL) begin
              mcand <= a;
              mplr  <= b;
              acc   <= 16'h0000;
              count <= 4'd0;
              busy  <= 1'b1;
              state <= MUL;
            end else begin
              result <= alu_res;
              cout   <= alu_cout;
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          count <= count + 4'd1;
          // Last iteration publishes the updated accumulator directly.
          if (count == 4'd15) begin
            result <= acc_next;
            cout   <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            count  <= 4'd0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec with a queue scoreboard checked on each done pulse.
module tb_alu_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  signal;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        busy;
  logic        done;

  alu_exec dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .signal (signal),
    .a      (a),
    .b      (b),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [15:0] res;
    logic        c;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("missed_done", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("cout",   32'(cout),   32'(e.c));
          chk("zero",   32'(zero),   32'(e.res == 16'h0000));
          chk("done_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dly: edges from the accept edge to the result edge; negative means the start should be ignored.
  task automatic op(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y,
                    input logic [15:0] er, input logic ec, input int dly);
    exp_t e;
    start  = 1'b1;
    signal = s;
    a      = x;
    b      = y;
    tick();
    start = 1'b0;
    if (dly >= 0) begin
      e.res = er;
      e.c   = ec;
      e.due = cyc + dly;
      sb.push_back(e);
    end
  endtask

  task automatic mul_run(input logic [15:0] x, input logic [15:0] y, input logic [15:0] er);
    op(3'b001, x, y, er, 1'b0, 16);
    chk("busy_accept", 32'(busy), 32'd1);
    repeat (15) begin
      tick();
      chk("busy_during", 32'(busy), 32'd1);
    end
    tick();
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    signal = 3'b000;
    a      = 16'h0000;
    b      = 16'h0000;
    #12;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_cout",   32'(cout),   32'h0);
    chk("rst_zero",   32'(zero),   32'h1);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_done",   32'(done),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // add with carry-out and zero result
    op(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0);
    chk("add_done_now", 32'(done), 32'h1);
    tick();
    chk("add_done_once", 32'(done), 32'h0);
    chk("add_hold", 32'(result), 32'h0);

    // multiplies, cout cleared by mul
    mul_run(16'h0003, 16'h0005, 16'h000F);
    tick();
    mul_run(16'h1234, 16'h0100, 16'h3400);
    tick();

    // start during the 5th busy cycle is ignored
    op(3'b001, 16'h0007, 16'h0009, 16'h003F, 1'b0, 16);
    repeat (3) tick();
    op(3'b000, 16'h0001, 16'h0001, 16'h0000, 1'b0, -1);
    repeat (12) tick();
    chk("ignored_busy_end", 32'(busy), 32'h0);
    repeat (2) tick();
    chk("ignored_final", 32'(result), 32'h003F);

    // reset during the 8th multiply cycle aborts it
    op(3'b001, 16'h00AA, 16'h0003, 16'h01FE, 1'b0, 16);
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",   32'(busy),   32'h0);
    chk("abort_done",   32'(done),   32'h0);
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_zero",   32'(zero),   32'h1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    op(3'b011, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 0);
    tick();

    // shifts use b[3:0] only; and to zero
    op(3'b100, 16'h0001, 16'h0013, 16'h0008, 1'b0, 0);
    op(3'b101, 16'h8000, 16'h000F, 16'h0001, 1'b0, 0);
    op(3'b010, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b0, 0);
    tick();

    // 110/111 alias to add
    op(3'b111, 16'h0002, 16'h0003, 16'h0005, 1'b0, 0);
    op(3'b110, 16'h8000, 16'h8001, 16'h0001, 1'b1, 0);
    tick();

    // back-to-back single-cycle ops keep done high
    op(3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 0);
    op(3'b011, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0);
    chk("b2b_done", 32'(done), 32'h1);
    op(3'b000, 16'h1111, 16'h2222, 16'h3333, 1'b0, 0);
    chk("b2b_done2", 32'(done), 32'h1);
    tick();

    // start accepted in the cycle right after mul completion
    mul_run(16'h0002, 16'h0003, 16'h0006);
    op(3'b000, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0);
    tick();

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    chk("sb_drain", 32'(sb.size()), 32'h0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
